// File: rtl/prim_ram_1p_pkg.sv
// Shared types for the request-driven single-port RAM front end.
package prim_ram_1p_pkg;

    typedef enum logic {
        StInit = 1'b0,
        StIdle = 1'b1
    } ram_state_e;

    // Command presented to the RAM; init selects counter/pattern over host fields.
    typedef struct packed {
        logic req;
        logic write;
        logic init;
    } ram_cmd_t;

    localparam int unsigned RspFifoDepth = 2;

    function automatic logic [1:0] occupancy(input logic inflight, input logic [1:0] count);
        return {1'b0, inflight} + count;
    endfunction

endpackage

// File: rtl/prim_fifo_sync.sv
// Small synchronous FIFO. The writer keeps occupancy within Depth; a write
// at full is taken only when a pop happens in the same cycle.
module prim_fifo_sync #(
    parameter int unsigned Width = 32,
    parameter bit          Pass  = 1'b0,
    parameter int unsigned Depth = 2,
    localparam int unsigned DepthW = $clog2(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wvalid_i,
    input  logic [Width-1:0]  wdata_i,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic [Width-1:0]  rdata_o,
    output logic [DepthW-1:0] depth_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0]  mem_q [Depth];
    logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DepthW-1:0] cnt_q, cnt_d;
    logic              empty, full, push, pop, pass_through;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign empty        = (cnt_q == '0);
    assign full         = (cnt_q == DepthW'(Depth));
    assign pass_through = Pass && empty;
    assign pop          = !empty && rready_i;
    assign push         = wvalid_i && (!full || pop) && !(pass_through && rready_i);
    assign rvalid_o     = !empty || (pass_through && wvalid_i);
    assign rdata_o      = pass_through ? wdata_i : mem_q[rptr_q];
    assign depth_o      = cnt_q;

    always_comb begin
        cnt_d  = cnt_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) wptr_d = ptr_inc(wptr_q);
        if (pop)  rptr_d = ptr_inc(rptr_q);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + DepthW'(1);
            2'b01:   cnt_d = cnt_q - DepthW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/prim_ram_1p_req.sv
// Valid/ready host front end for a single-port RAM with 1-cycle read latency,
// including whole-array initialisation to a fixed pattern.
module prim_ram_1p_req
    import prim_ram_1p_pkg::*;
#(
    parameter int unsigned      Width       = 32,
    parameter int unsigned      Depth       = 128,
    parameter logic [Width-1:0] InitPattern = '0,
    localparam int unsigned     Aw          = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_write_i,
    input  logic [Aw-1:0]    req_addr_i,
    input  logic [Width-1:0] req_wdata_i,
    input  logic [Width-1:0] req_wmask_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [Width-1:0] rsp_rdata_o,
    input  logic             init_req_i,
    output logic             init_done_o,
    output logic             ram_req_o,
    output logic             ram_write_o,
    output logic [Aw-1:0]    ram_addr_o,
    output logic [Width-1:0] ram_wdata_o,
    output logic [Width-1:0] ram_wmask_o,
    input  logic [Width-1:0] ram_rdata_i
);

    ram_state_e    state_q, state_d;
    logic [Aw-1:0] init_addr_q, init_addr_d;
    logic          inflight_q, inflight_d;
    logic          init_pend_q, init_pend_d;
    logic [1:0]    fifo_depth;
    logic          req_fire, init_want;
    ram_cmd_t      cmd;

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        init_pend_d = 1'b0;
        req_ready_o = 1'b0;
        init_done_o = 1'b0;
        cmd         = '0;
        init_want   = init_req_i || init_pend_q;
        case (state_q)
            StInit: begin
                cmd = '{req: 1'b1, write: 1'b1, init: 1'b1};
                if (init_addr_q == Aw'(Depth - 1)) state_d = StIdle;
                else                               init_addr_d = init_addr_q + Aw'(1);
            end
            StIdle: begin
                init_done_o = 1'b1;
                // Readiness looks only at stored/inflight responses, never at rsp_ready_i.
                req_ready_o = !init_want && (occupancy(inflight_q, fifo_depth) < 2'd2);
                if (init_want) begin
                    if (inflight_q) begin
                        init_pend_d = 1'b1;
                    end else begin
                        state_d     = StInit;
                        init_addr_d = '0;
                    end
                end
            end
            default: state_d = StInit;
        endcase
        req_fire = req_valid_i && req_ready_o;
        if (req_fire) cmd = '{req: 1'b1, write: req_write_i, init: 1'b0};
        inflight_d = req_fire && !req_write_i;
    end

    assign ram_req_o   = cmd.req;
    assign ram_write_o = cmd.write;
    assign ram_addr_o  = cmd.init ? init_addr_q : req_addr_i;
    assign ram_wdata_o = cmd.init ? InitPattern : req_wdata_i;
    assign ram_wmask_o = cmd.init ? {Width{1'b1}} : req_wmask_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StInit;
            init_addr_q <= '0;
            inflight_q  <= 1'b0;
            init_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            inflight_q  <= inflight_d;
            init_pend_q <= init_pend_d;
        end
    end

    prim_fifo_sync #(
        .Width (Width),
        .Pass  (1'b0),
        .Depth (RspFifoDepth)
    ) u_rsp_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .wvalid_i (inflight_q),
        .wdata_i  (ram_rdata_i),
        .rvalid_o (rsp_valid_o),
        .rready_i (rsp_ready_i),
        .rdata_o  (rsp_rdata_o),
        .depth_o  (fifo_depth)
    );

endmodule
